// File: rtl/trace_rd_pkg.sv
// ---------------------------------------------------------------------------
// trace_rd_pkg
//  Shared definitions for the trace buffer readout path:
//    - state_e     : readout FSM states
//    - TRACE_MAGIC : default tag carried in the frame header
//    - hdr_word()  : 32-bit header word {tag, limit}
//    - trl_word()  : 32-bit trailer word {count, folded checksum}
// ---------------------------------------------------------------------------
package trace_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_CAPT,
    ST_SEND,
    ST_TRL,
    ST_DONE
  } state_e;

  localparam logic [15:0] TRACE_MAGIC = 16'h7B01;

  // Header for a 32-bit payload: tag in the upper half, word limit below.
  function automatic logic [31:0] hdr_word(input logic [15:0] magic,
                                           input logic [15:0] limit);
    return {magic, limit};
  endfunction

  // Trailer: word count in the upper half, the 32-bit running XOR folded
  // down to 16 bits in the lower half.
  function automatic logic [31:0] trl_word(input logic [15:0] cnt,
                                           input logic [31:0] cs);
    return {cnt, cs[31:16] ^ cs[15:0]};
  endfunction

endpackage

// File: rtl/trace_out_reg.sv
// ---------------------------------------------------------------------------
// trace_out_reg
//  Output holding register for the framed stream. The FSM loads a word
//  (valid rises) and clears valid after the handshake. The data register is
//  only written on load, so the word stays stable for as long as the host
//  stalls.
// Ports:
//  clk    in   1  clock
//  rst_n  in   1  asynchronous active-low reset
//  load   in   1  capture din and raise valid
//  clear  in   1  drop valid (word was accepted)
//  din    in   W  word to present
//  data   out  W  presented word
//  valid  out  1  word is pending on the stream
// ---------------------------------------------------------------------------
module trace_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] data,
  output logic         valid
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // load has priority so a clear and a new word in the same cycle would
  // still present the new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end
    if (load) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/trace_buffer_reader.sv
// ---------------------------------------------------------------------------
// trace_buffer_reader
//  Readout side of the debug trace buffer. On a host request it drains the
//  buffer one word at a time and frames the words as header + data + trailer
//  on a valid/ready stream toward the JTAG host bridge. Trace capture is
//  frozen for the whole readout so the buffer cannot change under the read.
// Ports:
//  clk         in   1     clock shared with trace_buffer
//  reset       in   1     asynchronous active-low reset
//  start       in   1     readout request, only honoured when idle
//  max_words   in   Cntw  word limit (0 or above TB_Depth means TB_Depth)
//  tb_empty    in   1     trace buffer empty flag
//  tb_rd       out  1     one-cycle read strobe to the trace buffer
//  tb_dout     in   Fpay  read data, valid the cycle after tb_rd
//  freeze      out  1     disables trace capture while high
//  out_data    out  Fpay  framed stream data
//  out_valid   out  1     stream valid
//  out_ready   in   1     stream ready from the host bridge
//  busy        out  1     readout in progress
//  words_sent  out  Cntw  data words accepted by the host in this/last frame
// ---------------------------------------------------------------------------
module trace_buffer_reader
  import trace_rd_pkg::*;
#(
  parameter int          Fpay     = 32,
  parameter int          TB_Depth = 512,
  parameter logic [15:0] MAGIC    = TRACE_MAGIC,
  localparam int         Cntw     = $clog2(TB_Depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [Cntw-1:0] max_words,
  input  logic            tb_empty,
  output logic            tb_rd,
  input  logic [Fpay-1:0] tb_dout,
  output logic            freeze,
  output logic [Fpay-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [Cntw-1:0] words_sent
);

  state_e            state_q, state_d;
  logic              freeze_q, freeze_d;
  logic              busy_q, busy_d;
  logic [Cntw-1:0]   limit_q, limit_d;
  logic [Cntw-1:0]   words_sent_q, words_sent_d;
  logic [31:0]       checksum_q, checksum_d;

  logic [Cntw-1:0]   limit_clamp;
  logic [Fpay-1:0]   hdr_full;
  logic [Fpay-1:0]   trl_full;
  logic              out_load;
  logic              out_clear;
  logic [Fpay-1:0]   out_din;
  logic              rd_strobe;
  logic              xfer;

  // A zero limit or one beyond the buffer depth reads the whole buffer.
  always_comb begin
    if (max_words == '0 || max_words > Cntw'(TB_Depth)) begin
      limit_clamp = Cntw'(TB_Depth);
    end else begin
      limit_clamp = max_words;
    end
  end

  // The header is loaded on the IDLE->HDR transition, before limit_q holds
  // the new value, so it is built from the clamped request directly.
  generate
    if (Fpay == 32) begin : g_hdr_narrow
      assign hdr_full = hdr_word(MAGIC, 16'(limit_clamp));
    end else begin : g_hdr_wide
      assign hdr_full = {MAGIC, (Fpay - 16)'(limit_clamp)};
    end
  endgenerate

  assign trl_full = Fpay'(trl_word(16'(words_sent_q), checksum_q));

  assign xfer = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    freeze_d     = freeze_q;
    busy_d       = busy_q;
    limit_d      = limit_q;
    words_sent_d = words_sent_q;
    checksum_d   = checksum_q;
    out_load     = 1'b0;
    out_clear    = 1'b0;
    out_din      = '0;
    rd_strobe    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          limit_d      = limit_clamp;
          words_sent_d = '0;
          checksum_d   = '0;
          freeze_d     = 1'b1;
          busy_d       = 1'b1;
          out_load     = 1'b1;
          out_din      = hdr_full;
          state_d      = ST_HDR;
        end
      end

      ST_HDR: begin
        if (xfer) begin
          out_clear = 1'b1;
          state_d   = ST_RD;
        end
      end

      // The stream register is always empty here, so a read never overlaps
      // a pending word and at most one read is ever outstanding.
      ST_RD: begin
        if (tb_empty || words_sent_q == limit_q) begin
          out_load = 1'b1;
          out_din  = trl_full;
          state_d  = ST_TRL;
        end else begin
          rd_strobe = 1'b1;
          state_d   = ST_CAPT;
        end
      end

      ST_CAPT: begin
        out_load = 1'b1;
        out_din  = tb_dout;
        state_d  = ST_SEND;
      end

      ST_SEND: begin
        if (xfer) begin
          out_clear    = 1'b1;
          words_sent_d = words_sent_q + 1'b1;
          checksum_d   = checksum_q ^ out_data[31:0];
          state_d      = ST_RD;
        end
      end

      ST_TRL: begin
        if (xfer) begin
          out_clear = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        freeze_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        freeze_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      freeze_q     <= 1'b0;
      busy_q       <= 1'b0;
      limit_q      <= '0;
      words_sent_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      freeze_q     <= freeze_d;
      busy_q       <= busy_d;
      limit_q      <= limit_d;
      words_sent_q <= words_sent_d;
      checksum_q   <= checksum_d;
    end
  end

  trace_out_reg #(
    .W (Fpay)
  ) u_out_reg (
    .clk   (clk),
    .rst_n (reset),
    .load  (out_load),
    .clear (out_clear),
    .din   (out_din),
    .data  (out_data),
    .valid (out_valid)
  );

  // The strobe depends on the live empty flag, so it is decoded rather than
  // registered; it is high only for the single RD cycle that issues a read.
  assign tb_rd      = rd_strobe;
  assign freeze     = freeze_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule
